// File: rtl/booth_mul_sched.sv
// Four-channel round-robin scheduler that feeds one shared iterative multiplier and returns tagged results.
// Optional WAIT-state abort when BOOTH_SCHED_TIMEOUT_EN is defined; the default build has no timeout logic.
`timescale 1ns/1ps
module booth_mul_sched #(
  parameter int TIMEOUT = 40
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  req_valid,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [3:0]  req_ready,
  output logic        mul_start,
  output logic [7:0]  mul_a,
  output logic [7:0]  mul_b,
  input  logic        mul_done,
  input  logic [15:0] mul_p,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [1:0]  rsp_id,
  output logic [15:0] rsp_p,
  output logic        rsp_err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  if (TIMEOUT < 1) begin : g_timeout_chk
    $error("booth_mul_sched: TIMEOUT must be at least 1");
  end

  logic [1:0]  state;
  logic [1:0]  ptr;
  logic [1:0]  id_q;
  logic [7:0]  a_q;
  logic [7:0]  b_q;
  logic [15:0] p_q;
  logic [1:0]  gnt_id;
  logic [1:0]  cand;
  logic        gnt_found;
  logic        accept;

`ifdef BOOTH_SCHED_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CNT_W-1:0] wait_cnt;
  logic             err_q;
`endif

  // Round-robin search starting one past the last granted channel.
  always_comb begin
    gnt_id    = ptr;
    gnt_found = 1'b0;
    cand      = ptr;
    for (int off = 1; off <= 4; off++) begin
      cand = ptr + 2'(off);
      if (!gnt_found && req_valid[cand]) begin
        gnt_id    = cand;
        gnt_found = 1'b1;
      end
    end
  end

  assign accept = (state == IDLE) && gnt_found;

  // NOTE: req_ready is decoded combinationally, so the async reset must gate it directly; the register reset alone would not cover it.
  assign req_ready = (accept && !reset) ? (4'b0001 << gnt_id) : 4'b0000;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= 2'd3;
      id_q  <= 2'd0;
      a_q   <= 8'd0;
      b_q   <= 8'd0;
      p_q   <= 16'd0;
`ifdef BOOTH_SCHED_TIMEOUT_EN
      wait_cnt <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_q   <= req_a[{gnt_id, 3'b000} +: 8];
            b_q   <= req_b[{gnt_id, 3'b000} +: 8];
            id_q  <= gnt_id;
            state <= ISSUE;
`ifdef BOOTH_SCHED_TIMEOUT_EN
            err_q <= 1'b0;
`endif
          end
        end
        ISSUE: begin
          state <= WAIT;
`ifdef BOOTH_SCHED_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        WAIT: begin
          if (mul_done) begin
            p_q   <= mul_p;
            state <= RESP;
          end
`ifdef BOOTH_SCHED_TIMEOUT_EN
          else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
            p_q   <= 16'd0;
            err_q <= 1'b1;
            state <= RESP;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
`endif
        end
        RESP: begin
          if (rsp_ready) begin
            ptr   <= id_q;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mul_start = (state == ISSUE);
  assign mul_a     = a_q;
  assign mul_b     = b_q;
  assign rsp_valid = (state == RESP);
  assign rsp_id    = id_q;
  assign rsp_p     = p_q;

`ifdef BOOTH_SCHED_TIMEOUT_EN
  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_booth_mul_sched.sv
// Scoreboard bench for booth_mul_sched: a 16-cycle multiplier model, an arbitration reference and a response monitor.
// Define BOOTH_SCHED_TIMEOUT_EN for both files to include the timeout scenario.
`timescale 1ns/1ps
module tb_booth_mul_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [3:0]  req_ready;
  logic        mul_start;
  logic [7:0]  mul_a;
  logic [7:0]  mul_b;
  logic        mul_done;
  logic [15:0] mul_p;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_p;
  logic        rsp_err;

  booth_mul_sched dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .mul_start (mul_start),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_done  (mul_done),
    .mul_p     (mul_p),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_p     (rsp_p),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  id;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    total_cnt++;
    $display("FAIL %s: bounded wait expired", name);
  endtask

  // Iterative multiplier: done pulse 16 cycles after start; mul_p is noise except on done.
  logic       hold_done = 1'b0;
  logic       mm_busy   = 1'b0;
  int         mm_cnt;
  int         mm_ia;
  int         mm_ib;
  always begin
    @(posedge clk); #2;
    mul_done = 1'b0;
    mul_p    = 16'($urandom);
    if (mm_busy && !hold_done) begin
      mm_cnt--;
      if (mm_cnt == 0) begin
        mul_done = 1'b1;
        mul_p    = 16'(mm_ia * mm_ib);
        mm_busy  = 1'b0;
      end
    end
    if (mul_start) begin
      mm_busy = 1'b1;
      mm_cnt  = 16;
      mm_ia   = $signed(mul_a);
      mm_ib   = $signed(mul_b);
    end
  end

  function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [3:0] v);
    for (int k = 1; k <= 4; k++) begin
      int c = (int'(last) + k) % 4;
      if (v[c]) return 2'(c);
    end
    return last;
  endfunction

  // Reference model: who should be granted, and what the response must carry.
  logic [1:0] ptr_m;
  logic       busy_m    = 1'b0;
  logic       start_exp = 1'b0;
  logic       acc_seen  = 1'b0;
  logic [3:0] exp_rdy;
  logic [1:0] g_id;
  int         gi;
  int         ia;
  int         ib;
  exp_t       ent;
  always begin
    @(negedge clk); #1;
    if (reset) begin
      check("reset_outputs",
            {req_ready, mul_start, mul_a, mul_b, rsp_valid, rsp_id, rsp_p, rsp_err}, 64'd0);
      ptr_m     = 2'd3;
      busy_m    = 1'b0;
      start_exp = 1'b0;
      sb.delete();
    end else begin
      exp_rdy = 4'b0000;
      g_id    = 2'd0;
      if (!busy_m && req_valid != 4'b0000) begin
        g_id    = rr_pick(ptr_m, req_valid);
        exp_rdy = 4'b0001 << g_id;
      end
      check("req_ready_mul_start", {req_ready, mul_start}, {exp_rdy, start_exp});
      start_exp = 1'b0;
      if (exp_rdy != 4'b0000) begin
        gi      = int'(g_id);
        ent.id  = g_id;
        ent.a   = req_a[gi*8 +: 8];
        ent.b   = req_b[gi*8 +: 8];
        ia      = $signed(ent.a);
        ib      = $signed(ent.b);
        ent.err = hold_done;
        ent.p   = hold_done ? 16'h0000 : 16'(ia * ib);
        sb.push_back(ent);
        busy_m    = 1'b1;
        ptr_m     = g_id;
        start_exp = 1'b1;
        acc_seen  = 1'b1;
      end else if (busy_m && rsp_valid && rsp_ready) begin
        busy_m = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard on every response handshake.
  int         cyc = 0;
  int         start_cyc_m = 0;
  int         starts = 0;
  int         rsp_n = 0;
  logic       rv_prev = 1'b0;
  logic       done_prev = 1'b0;
  logic [1:0] last_id;
  logic [15:0] last_p;
  logic       last_err;
  logic [1:0] id_log[$];
  exp_t       got;
  always begin
    @(negedge clk);
    cyc++;
    if (reset) begin
      rv_prev   = 1'b0;
      done_prev = 1'b0;
      starts    = 0;
    end else begin
      if (mul_start) begin
        starts++;
        start_cyc_m = cyc;
      end
      if (rsp_valid && !rv_prev) begin
        if (hold_done) check("timeout_latency", 64'(cyc - start_cyc_m), 64'd41);
        else           check("rsp_after_done", 64'(done_prev), 64'd1);
      end
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          total_cnt++;
          $display("FAIL rsp_unexpected: got id %0d p %0h with empty scoreboard", rsp_id, rsp_p);
        end else begin
          got = sb.pop_front();
          check("rsp_fields", {rsp_id, rsp_p, rsp_err}, {got.id, got.p, got.err});
          check("operands_held", {mul_a, mul_b}, {got.a, got.b});
          check("one_start", 64'(starts), 64'd1);
        end
        starts   = 0;
        last_id  = rsp_id;
        last_p   = rsp_p;
        last_err = rsp_err;
        id_log.push_back(rsp_id);
        rsp_n++;
      end
      rv_prev   = rsp_valid;
      done_prev = mul_done;
    end
  end

  task automatic wait_accept(input string name);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk); #2;
      if (acc_seen) return;
    end
    fail_now(name);
  endtask

  task automatic send(input int ch, input logic [7:0] a, input logic [7:0] b);
    @(posedge clk); #1;
    req_a[ch*8 +: 8] = a;
    req_b[ch*8 +: 8] = b;
    req_valid = 4'(1 << ch);
    acc_seen  = 1'b0;
    wait_accept("accept");
    @(posedge clk); #1;
    req_valid = 4'b0000;
  endtask

  task automatic wait_rsp(input int target, input string name);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #2;
      if (rsp_n >= target) return;
    end
    fail_now(name);
  endtask

  task automatic drain();
    @(posedge clk); #1;
    req_valid = 4'b0000;
    rsp_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #2;
      if (!busy_m && sb.size() == 0) return;
    end
    fail_now("drain");
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [18:0] bp_snap;
  logic        rv_seen;
  initial begin
    reset     = 1'b0;
    req_valid = 4'hF;
    req_a     = 32'h0;
    req_b     = 32'h0;
    rsp_ready = 1'b1;
    mul_done  = 1'b0;
    mul_p     = 16'h0;
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    req_valid = 4'h0;

    // Single request on channel 2.
    send(2, 8'h03, 8'h05);
    wait_rsp(1, "single_rsp");
    check("single_p", {last_id, last_p, last_err}, {2'd2, 16'h000F, 1'b0});

    // Signed operands on channel 0.
    send(0, 8'hFC, 8'h07);
    wait_rsp(2, "signed_rsp");
    check("signed_p", {last_id, last_p}, {2'd0, 16'hFFE4});
    drain();

    // Fairness: all channels requesting from reset release.
    @(posedge clk); #1;
    reset = 1'b1;
    req_a = $urandom;
    req_b = $urandom;
    req_valid = 4'hF;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    id_log.delete();
    wait_rsp(rsp_n + 5, "fair_rsp");
    drain();
    check("fair_count", 64'(id_log.size() >= 5), 64'd1);
    for (int i = 0; i < 5; i++) check("fair_order", 64'(id_log[i]), 64'(i % 4));

    // Backpressure in RESP with other channels still requesting.
    rsp_ready = 1'b0;
    send(1, 8'h9A, 8'h3C);
    @(posedge clk); #1;
    req_valid = 4'b1001;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk); #2;
      if (rsp_valid) break;
    end
    check("bp_valid", 64'(rsp_valid), 64'd1);
    bp_snap = {rsp_id, rsp_p, rsp_err};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #2;
      check("bp_hold", {rsp_valid, rsp_id, rsp_p, rsp_err}, {1'b1, bp_snap});
      check("bp_quiet", {req_ready, mul_start}, 5'd0);
    end
    drain();

    // Reset mid-WAIT; the multiplier's late done must not produce a response.
    send(3, 8'h7F, 8'h80);
    repeat (6) @(posedge clk);
    #1 reset = 1'b1;
    req_valid = 4'hF;
    @(negedge clk); #2;
    check("reset_mid_wait", {req_ready, mul_start, mul_a, mul_b, rsp_valid, rsp_id, rsp_p, rsp_err}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    req_valid = 4'h0;
    rv_seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk); #2;
      rv_seen = rv_seen | rsp_valid;
    end
    check("late_done_ignored", 64'(rv_seen), 64'd0);

`ifdef BOOTH_SCHED_TIMEOUT_EN
    // Multiplier never completes: abort after TIMEOUT WAIT cycles.
    hold_done = 1'b1;
    send(1, 8'h12, 8'h34);
    wait_rsp(rsp_n + 1, "timeout_rsp");
    check("timeout_fields", {last_id, last_p, last_err}, {2'd1, 16'h0000, 1'b1});
    drain();
    hold_done = 1'b0;
    mm_busy   = 1'b0;
`endif

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 900; i++) begin
      @(posedge clk); #1;
      if ($urandom_range(3) == 0) begin
        req_valid = 4'($urandom);
        req_a     = $urandom;
        req_b     = $urandom;
      end
      rsp_ready = ($urandom_range(3) != 0);
    end
    drain();
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/booth_mul_sched.md
BOOTH_MUL_SCHED -- requirements
Module: booth_mul_sched

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 40: WAIT-state cycle limit before abort; only used with BOOTH_SCHED_TIMEOUT_EN.
REQ-002 The block SHALL have port clk, input, 1: clock; all state changes on rising edge.
REQ-003 The block SHALL have port reset, input, 1: reset, asynchronous, active-high.
REQ-004 The block SHALL have port req_valid, input, 4: per-channel request valid, channel i = bit i.
REQ-005 The block SHALL have port req_a, input, 32: channel i signed operand A = bits [8i+7:8i].
REQ-006 The block SHALL have port req_b, input, 32: channel i signed operand B = bits [8i+7:8i].
REQ-007 The block SHALL have port req_ready, output, 4: per-channel accept; a request transfers when valid and ready are both high.
REQ-008 The block SHALL have port mul_start, output, 1: single-cycle start pulse to the shared iterative multiplier.
REQ-009 The block SHALL have ports mul_a and mul_b, outputs, 8 each: operands to the multiplier, held stable from start until done.
REQ-010 The block SHALL have port mul_done, input, 1: multiplier completion pulse; mul_p valid in the same cycle.
REQ-011 The block SHALL have port mul_p, input, 16: signed product from the multiplier.
REQ-012 The block SHALL have ports rsp_valid (output, 1), rsp_ready (input, 1), rsp_id (output, 2), rsp_p (output, 16) and rsp_err (output, 1): tagged result handshake.

Function
REQ-013 FSM states SHALL be IDLE, ISSUE, WAIT, RESP.
REQ-014 In IDLE with any req_valid bit high, the block SHALL grant one channel round-robin, searching from ptr+1 upward and wrapping from 3 to 0, where ptr is the last granted channel.
REQ-015 In IDLE, req_ready SHALL be one-hot on the granted channel in the same cycle; it SHALL be all-zero in every other state and whenever req_valid is zero.
REQ-016 On accept, the block SHALL latch the operands and the channel id, then enter ISSUE.
REQ-017 ISSUE SHALL assert mul_start for exactly one cycle, then enter WAIT.
REQ-018 mul_a and mul_b SHALL come from the latched registers and stay unchanged from ISSUE through RESP.
REQ-019 mul_done SHALL be sampled only in WAIT and ignored in every other state.
REQ-020 On mul_done in WAIT, the block SHALL capture mul_p into rsp_p and enter RESP; rsp_valid SHALL rise the next cycle.
REQ-021 RESP SHALL hold rsp_valid, rsp_id, rsp_p and rsp_err stable until rsp_ready is high; on that cycle the block SHALL update ptr to the granted id and return to IDLE.
REQ-022 No new request SHALL be accepted before the return to IDLE, so at most one multiplication is in flight.
REQ-023 Minimum turnaround SHALL be accept at cycle 0, start at cycle 1, done at cycle k >= 2, rsp_valid at cycle k+1, and next accept one cycle after the rsp handshake.
REQ-024 rsp_p SHALL equal mul_p bit-exact with no width change.

Reset
REQ-025 While reset is high, the block SHALL force state to IDLE, ptr to 3 (so channel 0 is first priority), and zero on req_ready, mul_start, mul_a, mul_b, rsp_valid, rsp_id, rsp_p and rsp_err.
REQ-026 Reset asserted mid-operation in any state SHALL discard the in-flight transaction without producing a response; a late mul_done after release SHALL be ignored.

Configuration
REQ-027 With BOOTH_SCHED_TIMEOUT_EN defined, a counter SHALL clear on entry to WAIT and increment each WAIT cycle; on reaching TIMEOUT without mul_done, the block SHALL enter RESP with rsp_err=1 and rsp_p=0.
REQ-028 With BOOTH_SCHED_TIMEOUT_EN undefined, WAIT SHALL last until mul_done with no limit, rsp_err SHALL be tied to 0, and no counter logic SHALL exist.

Verification (bench models a 16-cycle multiplier)
REQ-029 Single request: ch2 with a=0x03, b=0x05 -> one mul_start, then rsp_id=2, rsp_p=0x000F, rsp_err=0.
REQ-030 Signed operands: ch0 with a=0xFC, b=0x07 -> rsp_p=0xFFE4.
REQ-031 Fairness: all four req_valid held high from reset release -> responses in order of rsp_id 0,1,2,3,0.
REQ-032 Backpressure: rsp_ready low for 5 cycles in RESP -> rsp fields stable, req_ready=0, mul_start=0 throughout.
REQ-033 Reset mid-WAIT -> all outputs 0 next cycle; a mul_done after release produces no rsp_valid.
REQ-034 With BOOTH_SCHED_TIMEOUT_EN and TIMEOUT=40, mul_done held low -> rsp_valid after 40 WAIT cycles with rsp_err=1 and rsp_p=0x0000.
